// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the 5-stage RISC-V core. It produces:
//   - EX operand forwarding selects (MEM result has priority over WB result),
//   - a one-cycle load-use stall with a bubble inserted into EX,
//   - branch/jump flushes of the younger instructions,
//   - stall sequencing for multi-cycle EX operations (mul/div) through a
//     two-state FSM with a small cycle counter,
//   - a free-running count of fetch-stall cycles.
//
// Parameters
//   MC_LATENCY : total EX cycles of a multi-cycle op, first cycle included
//                (2..16)
//   CNT_W      : width of the stall-cycle counter
//
// Ports
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   rs1d, rs2d              : source registers of the ID instruction
//   rs1e, rs2e, rde         : source/destination registers of the EX instruction
//   rdm, rdw                : destination registers of MEM / WB instructions
//   regwritem, regwritew    : register-write enables of MEM / WB
//   resultsrce0             : EX instruction is a load
//   pcsrce                  : taken branch/jump resolved in EX
//   mcstarte                : EX instruction is a multi-cycle op
//   stallf, stalld, stalle  : hold PC, if_id, id_iex
//   flushd, flushe, flushm  : clear if_id, id_iex, iex_imem
//   forwardae, forwardbe    : 00 regfile, 01 WB result, 10 MEM ALU result
//   mcbusy, mcdone          : multi-cycle op occupies EX / final cycle of it
//   stallcnt                : number of cycles with stallf asserted (wraps)
//
// While reset is high every output reads 0, including the combinational ones.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1d,
    input  logic [4:0]       rs2d,
    input  logic [4:0]       rs1e,
    input  logic [4:0]       rs2e,
    input  logic [4:0]       rde,
    input  logic [4:0]       rdm,
    input  logic [4:0]       rdw,
    input  logic             regwritem,
    input  logic             regwritew,
    input  logic             resultsrce0,
    input  logic             pcsrce,
    input  logic             mcstarte,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             flushd,
    output logic             flushe,
    output logic             flushm,
    output logic [1:0]       forwardae,
    output logic [1:0]       forwardbe,
    output logic             mcbusy,
    output logic             mcdone,
    output logic [CNT_W-1:0] stallcnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mc_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // mccnt value of the op's final (mcdone) cycle.
    localparam logic [3:0] MC_LAST = 4'(MC_LATENCY - 1);

    mc_state_e        state_q,    state_d;
    logic [3:0]       mccnt_q,    mccnt_d;
    logic [CNT_W-1:0] stallcnt_q, stallcnt_d;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       lwstall;
    logic       mc_start;
    logic       mc_last;
    logic       mcstall;
    logic       stall_front;

    // Forwarding select for one EX source operand. x0 is never forwarded,
    // and the younger (MEM) producer wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_mem,
        input logic       we_mem,
        input logic [4:0] rd_wb,
        input logic       we_wb
    );
        if (we_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            return FWD_MEM;
        end else if (we_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        state_d    = state_q;
        mccnt_d    = mccnt_q;

        fwd_a = fwd_sel(rs1e, rdm, regwritem, rdw, regwritew);
        fwd_b = fwd_sel(rs2e, rdm, regwritem, rdw, regwritew);

        lwstall = resultsrce0 && (rde != 5'd0) &&
                  ((rde == rs1d) || (rde == rs2d));

        // A branch resolved alongside a multi-cycle start wins: the op is
        // on the wrong path and must not occupy EX.
        mc_start = (state_q == S_IDLE) && mcstarte && !pcsrce;
        mc_last  = (state_q == S_BUSY) && (mccnt_q == MC_LAST);

        // EX is held on every cycle of the op except its last one; the op
        // leaves EX on the edge that ends the mcdone cycle.
        mcstall     = mc_start || ((state_q == S_BUSY) && !mc_last);
        stall_front = lwstall || mcstall;

        unique case (state_q)
            S_IDLE: begin
                if (mc_start) begin
                    state_d = S_BUSY;
                    mccnt_d = 4'd1;
                end
            end
            S_BUSY: begin
                if (mc_last) begin
                    state_d = S_IDLE;
                    mccnt_d = 4'd0;
                end else begin
                    mccnt_d = mccnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                mccnt_d = 4'd0;
            end
        endcase

        stallcnt_d = stall_front ? (stallcnt_q + CNT_W'(1)) : stallcnt_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            mccnt_q    <= 4'd0;
            stallcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mccnt_q    <= mccnt_d;
            stallcnt_q <= stallcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: combinational, forced low while reset is asserted so the
    // pipeline sees no stall/flush/forward activity during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        stallf    = 1'b0;
        stalld    = 1'b0;
        stalle    = 1'b0;
        flushd    = 1'b0;
        flushe    = 1'b0;
        flushm    = 1'b0;
        forwardae = FWD_RF;
        forwardbe = FWD_RF;
        mcbusy    = 1'b0;
        mcdone    = 1'b0;

        if (!reset) begin
            stallf    = stall_front;
            stalld    = stall_front;
            stalle    = mcstall;
            // MEM gets a bubble while the multi-cycle op is held in EX.
            flushm    = mcstall;
            flushd    = pcsrce;
            // A held EX stage is never cleared, even on a load-use hazard.
            flushe    = (lwstall || pcsrce) && !mcstall;
            forwardae = fwd_a;
            forwardbe = fwd_b;
            mcbusy    = mc_start || (state_q == S_BUSY);
            mcdone    = mc_last;
        end
    end

    assign stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed testbench for hazard_unit. A default-parameter instance covers
// reset, forwarding, load-use, branch flush and the multi-cycle sequence; a
// second instance with a 4-bit stall counter covers counter wrap-around.
// Inputs change 1 ns after the rising edge; outputs are read after settling,
// well before the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic       reset_w;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwritem, regwritew, resultsrce0, pcsrce, mcstarte;

    logic        stallf, stalld, stalle, flushd, flushe, flushm;
    logic [1:0]  forwardae, forwardbe;
    logic        mcbusy, mcdone;
    logic [31:0] stallcnt;

    logic        w_stallf, w_stalld, w_stalle, w_flushd, w_flushe, w_flushm;
    logic [1:0]  w_forwardae, w_forwardbe;
    logic        w_mcbusy, w_mcdone;
    logic [3:0]  w_stallcnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_unit #(.MC_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
        .resultsrce0(resultsrce0), .pcsrce(pcsrce), .mcstarte(mcstarte),
        .stallf(stallf), .stalld(stalld), .stalle(stalle),
        .flushd(flushd), .flushe(flushe), .flushm(flushm),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .mcbusy(mcbusy), .mcdone(mcdone), .stallcnt(stallcnt)
    );

    hazard_unit #(.MC_LATENCY(4), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset_w),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
        .resultsrce0(resultsrce0), .pcsrce(pcsrce), .mcstarte(mcstarte),
        .stallf(w_stallf), .stalld(w_stalld), .stalle(w_stalle),
        .flushd(w_flushd), .flushe(w_flushe), .flushm(w_flushm),
        .forwardae(w_forwardae), .forwardbe(w_forwardbe),
        .mcbusy(w_mcbusy), .mcdone(w_mcdone), .stallcnt(w_stallcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        regwritem = 0; regwritew = 0; resultsrce0 = 0; pcsrce = 0;
        mcstarte = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stallf"},    32'(stallf),    32'd0);
        check({tag, "_stalld"},    32'(stalld),    32'd0);
        check({tag, "_stalle"},    32'(stalle),    32'd0);
        check({tag, "_flushd"},    32'(flushd),    32'd0);
        check({tag, "_flushe"},    32'(flushe),    32'd0);
        check({tag, "_flushm"},    32'(flushm),    32'd0);
        check({tag, "_forwardae"}, 32'(forwardae), 32'd0);
        check({tag, "_forwardbe"}, 32'(forwardbe), 32'd0);
        check({tag, "_mcbusy"},    32'(mcbusy),    32'd0);
        check({tag, "_mcdone"},    32'(mcdone),    32'd0);
        check({tag, "_stallcnt"},  stallcnt,       32'd0);
    endtask

    task automatic check_mc(input string tag, input logic stall_exp,
                            input logic busy_exp, input logic done_exp);
        check({tag, "_stallf"}, 32'(stallf), 32'(stall_exp));
        check({tag, "_stalle"}, 32'(stalle), 32'(stall_exp));
        check({tag, "_flushm"}, 32'(flushm), 32'(stall_exp));
        check({tag, "_mcbusy"}, 32'(mcbusy), 32'(busy_exp));
        check({tag, "_mcdone"}, 32'(mcdone), 32'(done_exp));
    endtask

    initial begin
        clear_inputs();
        reset   = 1'b1;
        reset_w = 1'b1;

        // ---------------- Reset with active hazard conditions ----------------
        mcstarte = 1; rs1e = 5; rdm = 5; regwritem = 1;
        #1;
        check_outputs_zero("rst");
        tick();
        tick();
        check_outputs_zero("rst_held");
        reset = 1'b0;
        #1;
        check("rel_mcbusy",    32'(mcbusy),    32'd1);
        check("rel_stallf",    32'(stallf),    32'd1);
        check("rel_forwardae", 32'(forwardae), 32'b10);
        check("rel_stallcnt",  stallcnt,       32'd0);
        clear_inputs();
        #1;
        check("rel_idle_mcbusy", 32'(mcbusy), 32'd0);
        tick();
        check("rel_stallcnt_hold", stallcnt, 32'd0);

        // ---------------- Forwarding priority ----------------
        rs1e = 3; rdm = 3; rdw = 3; regwritem = 1; regwritew = 1;
        #1;
        check("fwd_a_mem", 32'(forwardae), 32'b10);
        check("fwd_b_none", 32'(forwardbe), 32'b00);
        rdm = 0;
        #1;
        check("fwd_a_wb", 32'(forwardae), 32'b01);
        rdw = 0;
        #1;
        check("fwd_a_x0", 32'(forwardae), 32'b00);
        // MEM match without write enable falls through to WB.
        rs2e = 9; rdm = 9; rdw = 9; regwritem = 0; regwritew = 1;
        #1;
        check("fwd_b_wb", 32'(forwardbe), 32'b01);
        regwritem = 1;
        #1;
        check("fwd_b_mem", 32'(forwardbe), 32'b10);
        check("fwd_stall_none", 32'(stallf), 32'd0);
        clear_inputs();
        tick();

        // ---------------- Load-use ----------------
        resultsrce0 = 1; rde = 7; rs2d = 7;
        #1;
        check("lu_stallf", 32'(stallf), 32'd1);
        check("lu_stalld", 32'(stalld), 32'd1);
        check("lu_flushe", 32'(flushe), 32'd1);
        check("lu_stalle", 32'(stalle), 32'd0);
        check("lu_flushm", 32'(flushm), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("lu_stallcnt", stallcnt, 32'd1);
        check("lu_released", 32'(stallf), 32'd0);
        // Load into x0 is not a hazard.
        resultsrce0 = 1; rde = 0; rs1d = 0;
        #1;
        check("lu_x0", 32'(stallf), 32'd0);
        clear_inputs();
        tick();

        // ---------------- Branch flush ----------------
        pcsrce = 1;
        #1;
        check("br_flushd", 32'(flushd), 32'd1);
        check("br_flushe", 32'(flushe), 32'd1);
        check("br_stallf", 32'(stallf), 32'd0);
        mcstarte = 1;
        #1;
        check("br_mc_mcbusy", 32'(mcbusy), 32'd0);
        check("br_mc_stallf", 32'(stallf), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("br_mc_no_busy", 32'(mcbusy), 32'd0);
        check("br_stallcnt",   stallcnt,    32'd1);

        // ---------------- Multi-cycle op ----------------
        mcstarte = 1;
        #1;
        check_mc("mc1", 1'b1, 1'b1, 1'b0);
        tick();
        check_mc("mc2", 1'b1, 1'b1, 1'b0);
        tick();
        check_mc("mc3", 1'b1, 1'b1, 1'b0);
        // Load-use inside the held window: stalls stay, EX is not cleared.
        resultsrce0 = 1; rde = 7; rs1d = 7;
        #1;
        check("mc3_lu_stallf", 32'(stallf), 32'd1);
        check("mc3_lu_flushe", 32'(flushe), 32'd0);
        resultsrce0 = 0; rde = 0; rs1d = 0;
        tick();
        check_mc("mc4", 1'b0, 1'b1, 1'b1);
        check("mc4_stallcnt", stallcnt, 32'd4);
        // mcstarte still high after mcdone: a fresh op starts from IDLE.
        tick();
        check_mc("mc_new1", 1'b1, 1'b1, 1'b0);
        check("mc_new_stallcnt", stallcnt, 32'd4);
        tick();
        tick();
        check_mc("mc_new3", 1'b1, 1'b1, 1'b0);

        // ---------------- Abort by reset mid-op ----------------
        rs1e = 5; rdm = 5; regwritem = 1;
        #1;
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        tick();
        clear_inputs();
        reset = 1'b0;
        #1;
        check("abort_mcbusy", 32'(mcbusy), 32'd0);
        check("abort_stallf", 32'(stallf), 32'd0);
        tick();
        check("abort_idle_mcbusy", 32'(mcbusy), 32'd0);
        check("abort_idle_mcdone", 32'(mcdone), 32'd0);

        // ---------------- Counter wrap (CNT_W = 4) ----------------
        reset_w = 1'b0;
        #1;
        check("wrap_start", 32'(w_stallcnt), 32'd0);
        resultsrce0 = 1; rde = 7; rs2d = 7;
        for (int i = 0; i < 16; i++) tick();
        check("wrap_16",   32'(w_stallcnt), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("wrap_17",   32'(w_stallcnt), 32'd1);
        check("nowrap_17", stallcnt,        32'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. Generates forwarding selects, load-use stalls, branch flushes and multi-cycle-execute stalls that drive the enables and `clear` inputs of the if_id, id_iex and iex_imem pipeline registers. It sequences multi-cycle EX operations (mul/div) with an internal FSM. It also keeps a free-running stall-cycle performance counter.

## Interface
- `MC_LATENCY`, 4: total EX-stage cycles of a multi-cycle op, including its first cycle; legal range 2..16.
- `CNT_W`, 32: width of the stall performance counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rs1d`, `rs2d` input 5: source registers of the instruction in ID.
- `rs1e`, `rs2e`, `rde` input 5: source and destination registers of the instruction in EX.
- `rdm`, `rdw` input 5: destination registers of the instructions in MEM and WB.
- `regwritem`, `regwritew` input 1: register-write enables of MEM and WB.
- `resultsrce0` input 1: the EX instruction is a load.
- `pcsrce` input 1: taken branch or jump resolved in EX.
- `mcstarte` input 1: the EX instruction is a multi-cycle op.
- `stallf`, `stalld`, `stalle` output 1: hold the PC, if_id and id_iex.
- `flushd`, `flushe`, `flushm` output 1: clear if_id, id_iex (its `clear`) and iex_imem.
- `forwardae`, `forwardbe` output 2: ALU operand select. 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `mcbusy` output 1: a multi-cycle op occupies EX.
- `mcdone` output 1: final cycle of a multi-cycle op.
- `stallcnt` output `CNT_W`: count of cycles with `stallf`=1.

## Operation
- **Forwarding (combinational).**
  - `forwardae` = 10 if `regwritem` & `rdm`!=0 & `rdm`==`rs1e`.
  - Otherwise 01 if `regwritew` & `rdw`!=0 & `rdw`==`rs1e`.
  - Otherwise 00.
  - MEM has priority over WB. `forwardbe` is identical using `rs2e`.
- **Load-use.** `lwstall` = `resultsrce0` & `rde`!=0 & (`rde`==`rs1d` | `rde`==`rs2d`).
- **FSM states:** IDLE and BUSY, plus a counter `mccnt` (4 bits).
  - IDLE, with `mcstarte`=1 and `pcsrce`=0: go to BUSY, `mccnt`<=1.
  - BUSY with `mccnt`==`MC_LATENCY`-1: go to IDLE, `mccnt`<=0.
  - BUSY otherwise: `mccnt`<=`mccnt`+1.
- **Multi-cycle stall.** `mcstall` = (IDLE & `mcstarte` & !`pcsrce`) | (BUSY & `mccnt`!=`MC_LATENCY`-1).
- **Busy and done flags.**
  - `mcbusy` = (IDLE & `mcstarte` & !`pcsrce`) | BUSY.
  - `mcdone` = BUSY & `mccnt`==`MC_LATENCY`-1.
- **Stall and flush outputs.**
  - `stallf` = `stalld` = `lwstall` | `mcstall`.
  - `stalle` = `mcstall`.
  - `flushm` = `mcstall`: inserts a bubble into MEM while EX is held.
  - `flushd` = `pcsrce`.
  - `flushe` = (`lwstall` | `pcsrce`) & !`mcstall`. A held EX stage is never cleared.
- **Simultaneous events.**
  - `pcsrce` and `mcstarte` together in IDLE: the branch wins and no BUSY entry occurs. This combination is illegal from the decoder.
  - `lwstall` during `mcstall`: stalls stay asserted and `flushe`=0.
  - A new `mcstarte` in the cycle after `mcdone` starts a fresh op from IDLE.
- **Counter.** `stallcnt` increments by 1 on each rising edge where `stallf`=1. It wraps modulo 2^`CNT_W`.

## Timing
- **Reset.** While `reset`=1, all outputs are forced to 0 asynchronously, including `forwardae`/`forwardbe`=00. State goes to IDLE, `mccnt`=0, `stallcnt`=0.
- **Reset mid-operation.** Reset while BUSY aborts the op immediately. After release the FSM is in IDLE.
- **Latency of forwarding, stall and flush outputs.** Combinational from inputs and current state; zero-cycle latency.
- **Multi-cycle op.** Stalls are asserted for exactly `MC_LATENCY`-1 cycles starting in the cycle `mcstarte` is first seen. The op leaves EX on the edge ending the `mcdone` cycle.
- **Load-use.** Exactly one stall cycle per hazard. The bubble enters EX on the following edge.
- **State updates.** FSM, `mccnt` and `stallcnt` update only on the rising edge of `clk`.

## Test plan
- **Reset.** Assert `reset` with `mcstarte`=1, `rs1e`=`rdm`=5, `regwritem`=1 -> all outputs 0. Release; next edge: `stallcnt`=0, `mcbusy`=1 combinationally.
- **Forwarding priority.** `rs1e`=3, `rdm`=3, `rdw`=3, both regwrite=1 -> `forwardae`=10. Set `rdm`=0 -> 01. Set `rdw`=0 -> 00 (x0 never forwarded).
- **Load-use.** `resultsrce0`=1, `rde`=7, `rs2d`=7 -> `stallf`=`stalld`=`flushe`=1 for one cycle; `stallcnt` +1.
- **Branch flush.** `pcsrce`=1 -> `flushd`=`flushe`=1, stalls 0. `pcsrce` with `mcstarte` -> no BUSY entry.
- **Multi-cycle op, `MC_LATENCY`=4.** Pulse `mcstarte` held until done -> `stallf`/`stalle`/`flushm`=1 for 3 cycles, `mcdone`=1 in the 4th, `stallcnt`=3. Then a load-use in the same window -> `flushe` stays 0.
- **Abort and wrap.** `reset` asserted in the 2nd BUSY cycle -> IDLE, outputs 0. With `CNT_W`=4 and 17 stall cycles -> `stallcnt`=1.
